// File: rtl/universal_shift_register_n.sv
// universal_shift_register_n: WIDTH-bit universal shift register with a start/busy/done burst engine
module universal_shift_register_n #(
    parameter int WIDTH = 8,
    parameter int CW = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             MSB_in,
    input  logic             LSB_in,
    input  logic [WIDTH-1:0] I_par,
    input  logic             start,
    input  logic [CW-1:0]    amount,
    output logic [WIDTH-1:0] A_par,
    output logic             MSB_out,
    output logic             LSB_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] lmode, lmode_n;
    logic [WIDTH-1:0] a_n;
    logic done_n;
    logic shift_class;

    function automatic logic [WIDTH-1:0] step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] a,
        input logic             msb,
        input logic             lsb,
        input logic [WIDTH-1:0] p
    );
        case (m)
            3'd1:    step = {msb, a[WIDTH-1:1]};
            3'd2:    step = {a[WIDTH-2:0], lsb};
            3'd3:    step = p;
            3'd4:    step = {a[0], a[WIDTH-1:1]};
            3'd5:    step = {a[WIDTH-2:0], a[WIDTH-1]};
            3'd6:    step = {a[WIDTH-1], a[WIDTH-1:1]};
            3'd7:    step = '0;
            default: step = a;
        endcase
    endfunction

    assign shift_class = (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6});
    assign busy        = (state == RUN);
    assign MSB_out     = A_par[WIDTH-1];
    assign LSB_out     = A_par[0];

    // State and datapath registers; Clear wipes everything, aborting any burst
    always_ff @(posedge CLK) begin
        if (!Clear) begin
            state <= IDLE;
            cnt   <= '0;
            lmode <= 3'd0;
            A_par <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            lmode <= lmode_n;
            A_par <= a_n;
            done  <= done_n;
        end
    end

    // Next state: burst steps from the latched mode, otherwise start/en act once on live mode
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lmode_n = lmode;
        a_n     = A_par;
        done_n  = 1'b0;
        if (state == RUN) begin
            if (cnt == '0) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else begin
                a_n   = step(lmode, A_par, MSB_in, LSB_in, I_par);
                cnt_n = cnt - 1'b1;
            end
        end else if (start && shift_class) begin
            state_n = RUN;
            cnt_n   = amount;
            lmode_n = mode;
        end else if (start || en) begin
            a_n = step(mode, A_par, MSB_in, LSB_in, I_par);
        end
    end
endmodule

// File: tb/tb_universal_shift_register_n.sv
// tb_universal_shift_register_n: directed plus randomized checks against a timeline-based reference model
module tb_universal_shift_register_n;
    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          CLK = 1'b0;
    logic          Clear = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic          MSB_in = 1'b0;
    logic          LSB_in = 1'b0;
    logic [W-1:0]  I_par = '0;
    logic          start = 1'b0;
    logic [CW-1:0] amount = '0;
    logic [W-1:0]  A_par;
    logic          MSB_out, LSB_out, busy, done;

    int checks = 0;
    int failures = 0;

    // Reference model: a burst is remembered as (accept edge, length, mode)
    int           edge_no = 0;
    bit           acc_valid = 0;
    int           acc_e = 0;
    int           acc_n = 0;
    logic [2:0]   acc_m = 3'd0;
    logic [W-1:0] m_a = '0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;

    universal_shift_register_n #(.WIDTH(W), .CW(CW)) dut (
        .CLK(CLK), .Clear(Clear), .en(en), .mode(mode), .MSB_in(MSB_in), .LSB_in(LSB_in),
        .I_par(I_par), .start(start), .amount(amount), .A_par(A_par), .MSB_out(MSB_out),
        .LSB_out(LSB_out), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, edge_no);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] m, input logic [W-1:0] a,
                                            input logic msb, input logic lsb, input logic [W-1:0] p);
        case (m)
            3'd1:    return (a >> 1) | (W'(msb) << (W - 1));
            3'd2:    return (a << 1) | W'(lsb);
            3'd3:    return p;
            3'd4:    return (a >> 1) | (a << (W - 1));
            3'd5:    return (a << 1) | (a >> (W - 1));
            3'd6:    return W'($signed(a) >>> 1);
            3'd7:    return '0;
            default: return a;
        endcase
    endfunction

    task automatic cycle();
        edge_no++;
        if (!Clear) begin
            m_a = '0;
            acc_valid = 0;
        end else if (acc_valid && edge_no <= acc_e + acc_n + 1) begin
            if (edge_no <= acc_e + acc_n) m_a = ref_op(acc_m, m_a, MSB_in, LSB_in, I_par);
        end else if (start && (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
            acc_valid = 1;
            acc_e = edge_no;
            acc_n = int'(amount);
            acc_m = mode;
        end else if (start || en) begin
            m_a = ref_op(mode, m_a, MSB_in, LSB_in, I_par);
        end
        m_busy = acc_valid && edge_no >= acc_e && edge_no <= acc_e + acc_n;
        m_done = acc_valid && edge_no == acc_e + acc_n + 1;
        @(posedge CLK);
        #1;
        check("A_par", 32'(A_par), 32'(m_a));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("MSB_out", 32'(MSB_out), 32'(m_a[W-1]));
        check("LSB_out", 32'(LSB_out), 32'(m_a[0]));
    endtask

    task automatic single(input logic [2:0] m);
        mode = m;
        en = 1'b1;
        cycle();
        en = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] v);
        I_par = v;
        single(3'd3);
    endtask

    // Runs a burst with en/mode scrambled while busy; returns busy and done cycle counts
    task automatic burst(input logic [2:0] m, input logic [CW-1:0] n, output int bc, output int dc);
        mode = m;
        amount = n;
        start = 1'b1;
        cycle();
        start = 1'b0;
        bc = int'(busy);
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom);
            mode = 3'($urandom);
            cycle();
            bc += int'(busy);
            dc += int'(done);
            if (done) break;
        end
        en = 1'b0;
        mode = 3'd0;
        cycle();
        dc += int'(done);
    endtask

    initial begin
        int bc, dc, seen;
        cycle();
        cycle();
        check("rst_A", 32'(A_par), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        Clear = 1'b1;
        load(8'hA5);
        check("load", 32'(A_par), 32'hA5);

        single(3'd7);
        MSB_in = 1'b1;
        single(3'd1);
        check("shr_in1", 32'(A_par), 32'h80);
        MSB_in = 1'b0;
        LSB_in = 1'b1;
        single(3'd2);
        check("shl_in1", 32'(A_par), 32'h01);
        LSB_in = 1'b0;
        single(3'd7);
        check("zero", 32'(A_par), 32'h00);

        load(8'hA5);
        burst(3'd5, 4'd3, bc, dc);
        check("rotl_busy_cycles", 32'(bc), 32'd4);
        check("rotl_done_pulses", 32'(dc), 32'd1);
        check("rotl_result", 32'(A_par), 32'h2D);

        load(8'h96);
        burst(3'd6, 4'd2, bc, dc);
        check("asr_result", 32'(A_par), 32'hE5);
        burst(3'd6, 4'd0, bc, dc);
        check("amt0_busy_cycles", 32'(bc), 32'd1);
        check("amt0_done_pulses", 32'(dc), 32'd1);
        check("amt0_result", 32'(A_par), 32'hE5);

        load(8'hFF);
        MSB_in = 1'b0;
        mode = 3'd1;
        amount = 4'd8;
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        Clear = 1'b0;
        cycle();
        check("abort_A", 32'(A_par), 32'h00);
        check("abort_busy", 32'(busy), 32'd0);
        Clear = 1'b1;
        seen = 0;
        repeat (12) begin
            cycle();
            seen += int'(done);
        end
        check("abort_no_done", 32'(seen), 32'd0);

        load(8'h3C);
        mode = 3'd4;
        amount = 4'd2;
        start = 1'b1;
        en = 1'b1;
        cycle();
        start = 1'b0;
        en = 1'b0;
        check("prio_busy", 32'(busy), 32'd1);
        check("prio_A_unchanged", 32'(A_par), 32'h3C);
        for (int i = 0; i < 20 && !done; i++) cycle();
        check("prio_done_reached", 32'(done), 32'd1);
        check("prio_result", 32'(A_par), 32'h0F);
        mode = 3'd5;
        amount = 4'd1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        repeat (4) cycle();
        check("b2b_result", 32'(A_par), 32'h1E);

        repeat (400) begin
            Clear = ($urandom_range(0, 99) >= 3);
            en = 1'($urandom);
            start = ($urandom_range(0, 99) < 20);
            mode = 3'($urandom);
            amount = CW'($urandom);
            MSB_in = 1'($urandom);
            LSB_in = 1'($urandom);
            I_par = W'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/universal_shift_register_n.md
# universal_shift_register_n

Parametrised universal shift register, the successor to the fixed 4-bit universal shift register. It is WIDTH bits wide and supports eight operating modes, including rotate and arithmetic shift. A start/busy/done burst engine applies a shift or rotate a programmed number of times, one step per clock, without the host re-issuing commands. It sits in the registers/counters library as the general-purpose shifter for serial/parallel conversion and shift-based arithmetic.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2 and up.
- CW, $clog2(WIDTH)+1, width of the burst amount and internal step counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Clear  input  1  reset, synchronous and active-low.
- en  input  1  single-step enable; applies `mode` once at this edge.
- mode  input  3  operation select (see Operation).
- MSB_in  input  1  serial input entering bit WIDTH-1 on shift right.
- LSB_in  input  1  serial input entering bit 0 on shift left.
- I_par  input  WIDTH  parallel load data.
- start  input  1  burst request, sampled only when idle.
- amount  input  CW  burst step count, sampled with `start`.
- A_par  output  WIDTH  register contents (registered).
- MSB_out  output  1  combinational copy of A_par[WIDTH-1].
- LSB_out  output  1  combinational copy of A_par[0].
- busy  output  1  high while a burst is in progress (registered).
- done  output  1  one-cycle pulse when a burst completes (registered).

## Operation
Modes:
- 000: hold.
- 001: shift right; A[i] <= A[i+1], A[W-1] <= MSB_in.
- 010: shift left; A[i] <= A[i-1], A[0] <= LSB_in.
- 011: parallel load; A <= I_par.
- 100: rotate right; A[W-1] <= A[0].
- 101: rotate left; A[0] <= A[W-1].
- 110: arithmetic shift right; A[W-1] is kept and replicated into the vacated position.
- 111: synchronous zero; A <= 0.

States: IDLE and RUN.
- **IDLE, start=1 with a shift-class mode** (001, 010, 100, 101, 110): latch the mode and amount into internal registers, go to RUN. A_par is unchanged at this edge.
- **IDLE, start=1 with a non-shift mode** (000, 011, 111): execute that mode once, exactly as for `en`. busy and done stay 0.
- **IDLE, start=0, en=1:** execute `mode` once. With both start and en low, hold.
- **start and en together:** start has priority.
- **RUN, counter != 0:** apply the latched mode once and decrement the counter.
- **RUN, counter == 0:** go to IDLE and assert done for one cycle. No register change at this edge.
- **Ignored during RUN:** en, mode, start, amount, I_par.
- **Serial inputs during a burst:** MSB_in and LSB_in are sampled live at every step, not latched at start.
- **amount == 0:** busy is high for 1 cycle, then done; A_par is unchanged.
- **amount > WIDTH:** exactly `amount` steps are performed. Rotates wrap; shifts flush in serial or sign data.
- **Reset:** Clear low at any edge, including mid-burst, forces A_par=0, busy=0, done=0, counter=0, state IDLE. A burst aborted by reset never produces done.

## Timing
- **Single step:** A_par reflects the result one edge after en or start (non-shift mode) is sampled.
- **Burst of N steps:** let start be accepted at edge k.
  - busy is high from edge k through edge k+N+1, i.e. N+1 cycles.
  - Steps are applied at edges k+1 through k+N.
  - At edge k+N+1, busy falls and done rises; done falls at edge k+N+2.
- **Back-to-back bursts:** a new start may be accepted in the cycle done is high. Minimum spacing between accepts is N+2 edges.
- **Combinational paths:** only MSB_out and LSB_out. No combinational path from any input to any output.

## Test plan
All values below use WIDTH=8.
- **Reset and load:** hold Clear low for 2 cycles, check A_par=0x00, busy=0, done=0. Then mode=011, I_par=0xA5, en=1 for 1 cycle, check A_par=0xA5 after 1 edge.
- **Single shifts:** from 0x00, mode=001 with MSB_in=1 for one en step gives 0x80. Then mode=010 with LSB_in=1 for one step gives 0x01. Then mode=111 gives 0x00.
- **Rotate-left burst:** A=0xA5, start with mode=101, amount=3. busy is high for 4 cycles, A ends 0x2D, done is a single 1-cycle pulse. Toggling en/mode mid-burst has no effect.
- **Arithmetic-shift-right burst:** A=0x96, start with mode=110, amount=2 gives 0xE5. Then amount=0 gives busy for 1 cycle, done, A still 0xE5.
- **Reset mid-burst:** A=0xFF, start with mode=001, MSB_in=0, amount=8. Drive Clear low at the 3rd busy cycle: A_par=0x00 and busy=0 on the next edge, and done never asserts.
- **Priority and back-to-back:** start and en high together with mode=100 runs a burst, not a single step. A second start issued in the done cycle is accepted and busy rises immediately.
